// File: rtl/line_cycle_detector.sv
// Line-cycle recogniser: hysteresis zero-crossing detector with min-period holdoff,
// loss-of-lock timeout, measured period and sticky glitch/loss flags.
module line_cycle_detector #(
   parameter int unsigned SAMPLE_WIDTH = 12,
   parameter int unsigned HYST         = 16,
   parameter int unsigned MIN_PERIOD   = 64,
   parameter int unsigned MAX_PERIOD   = 4000,
   parameter int unsigned CNT_WIDTH    = 12
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           enable_i,
   input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
   input  logic                           sample_valid_i,
   input  logic                           clear_i,
   output logic                           cycle_pulse_o,
   output logic [CNT_WIDTH-1:0]           period_o,
   output logic                           period_valid_o,
   output logic                           locked_o,
   output logic                           glitch_o,
   output logic                           lost_o
);

   typedef enum logic [1:0] {StAcquire, StFirstNeg, StPos, StNeg} state_e;

   localparam logic signed [SAMPLE_WIDTH-1:0] HystPos = SAMPLE_WIDTH'(HYST);
   localparam logic signed [SAMPLE_WIDTH-1:0] HystNeg = -HystPos;
   localparam logic [CNT_WIDTH-1:0] MinPeriod = CNT_WIDTH'(MIN_PERIOD);
   localparam logic [CNT_WIDTH-1:0] MaxPeriod = CNT_WIDTH'(MAX_PERIOD);

   state_e               state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 pos, neg, accept, reject, timeout, take;
   logic                 glitch_set, lost_set;

   always_comb begin
      pos        = sample_i >= HystPos;
      neg        = sample_i <= HystNeg;
      cnt_next   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
      take       = enable_i && sample_valid_i;
      accept     = (state_q == StNeg) && pos && (cnt_next >= MinPeriod);
      reject     = (state_q == StNeg) && pos && (cnt_next < MinPeriod);
      // An accepted edge outranks the timeout on the same sample.
      timeout    = (state_q != StAcquire) && !accept && (cnt_next >= MaxPeriod);
      glitch_set = take && reject && !timeout;
      lost_set   = take && timeout;
   end

   assign locked_o = (state_q == StPos) || (state_q == StNeg);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StAcquire;
         cnt_q          <= '0;
         cycle_pulse_o  <= 1'b0;
         period_valid_o <= 1'b0;
         period_o       <= '0;
         glitch_o       <= 1'b0;
         lost_o         <= 1'b0;
      end else begin
         cycle_pulse_o  <= 1'b0;
         period_valid_o <= 1'b0;
         glitch_o       <= glitch_set | (glitch_o & ~clear_i);
         lost_o         <= lost_set | (lost_o & ~clear_i);
         if (!enable_i) begin
            state_q <= StAcquire;
            cnt_q   <= '0;
         end else if (sample_valid_i) begin
            if (accept) begin
               state_q        <= StPos;
               cnt_q          <= '0;
               cycle_pulse_o  <= 1'b1;
               period_valid_o <= 1'b1;
               period_o       <= cnt_next;
            end else if (timeout) begin
               state_q <= StAcquire;
               cnt_q   <= '0;
            end else begin
               case (state_q)
                  StAcquire: begin
                     if (neg) state_q <= StFirstNeg;
                     cnt_q <= '0;
                  end
                  StFirstNeg: begin
                     // First rising edge only establishes phase.
                     if (pos) begin
                        state_q <= StPos;
                        cnt_q   <= '0;
                     end else begin
                        cnt_q <= cnt_next;
                     end
                  end
                  StPos: begin
                     if (neg) state_q <= StNeg;
                     cnt_q <= cnt_next;
                  end
                  StNeg: begin
                     // Rejected edge keeps counting so the true edge sees the full period.
                     if (pos) state_q <= StPos;
                     cnt_q <= cnt_next;
                  end
                  default: begin
                     state_q <= StAcquire;
                     cnt_q   <= '0;
                  end
               endcase
            end
         end
      end
   end

endmodule
